// File: rtl/pipe_out_pkg.sv
// pipe_out_pkg: shared widths, word type and parity helper
// for the pipeline output FIFO.
package pipe_out_pkg;

  localparam int PIPE_WIDTH     = 16;
  localparam int PIPE_OUT_DEPTH = 8;

  typedef logic [PIPE_WIDTH-1:0] pipe_word_t;

  // Bit that makes the total number of ones even.
  function automatic logic even_par(pipe_word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/pipe_out_mem.sv
// pipe_out_mem: FIFO storage array with one clocked write
// port and one asynchronous read port; contents are not reset.
module pipe_out_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_out_fifo.sv
// pipe_out_fifo: buffers the free-running pipeline output and
// replays it over ready/valid. Option: PIPE_OUT_PARITY_EN.
module pipe_out_fifo
  import pipe_out_pkg::*;
#(
  parameter int WIDTH     = PIPE_WIDTH,
  parameter int DEPTH     = PIPE_OUT_DEPTH,
  parameter int AFULL_LVL = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef PIPE_OUT_PARITY_EN
  ,
  output logic                     out_par_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);
  localparam logic [PW-1:0] ONE     = PW'(1);

`ifdef PIPE_OUT_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          full, push, pop, drop;
  logic [MW-1:0] wdata, rdata;

  assign full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE;
    unique case (1'b1)
      push & ~pop: count_d = count_q + ONE;
      pop & ~push: count_d = count_q - ONE;
      default:     count_d = count_q;
    endcase
    // A drop outranks a coincident clear.
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef PIPE_OUT_PARITY_EN
  assign wdata = {even_par(pipe_word_t'(in_data)), in_data};
  assign out_data = rdata[WIDTH-1:0];
  assign out_par_err = out_valid &
    (even_par(pipe_word_t'(rdata[WIDTH-1:0])) != rdata[WIDTH]);
`else
  assign wdata    = in_data;
  assign out_data = rdata;
`endif

  pipe_out_mem #(
    .W     (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_C);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pipe_out_fifo.sv
// tb_pipe_out_fifo: directed and random checks of pipe_out_fifo
// against a queue-based reference model.
module tb_pipe_out_fifo;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        almost_full;
  logic        overflow;
  logic        ovf_clr = 1'b0;
`ifdef PIPE_OUT_PARITY_EN
  logic        out_par_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mq[$];
  logic        m_ovf = 1'b0;

  pipe_out_fifo #(
    .WIDTH(16), .DEPTH(DEPTH), .AFULL_LVL(AFULL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count),
    .almost_full(almost_full), .overflow(overflow),
    .ovf_clr(ovf_clr)
`ifdef PIPE_OUT_PARITY_EN
    , .out_par_err(out_par_err)
`endif
  );

  always #5 clk = ~clk;

  // Advance the model with the currently driven inputs, then clock.
  task automatic clk_step();
    bit pop, full, drop;
    pop  = (mq.size() != 0) && out_ready;
    full = (mq.size() == DEPTH);
    drop = in_valid && full && !pop;
    if (pop) void'(mq.pop_front());
    if (in_valid && (!full || pop)) mq.push_back(in_data);
    m_ovf = drop | (m_ovf & ~ovf_clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; ovf_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    mq.delete();
    m_ovf = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    n_cmp++;
    if (count !== 4'd0 || out_valid !== 1'b0 ||
        almost_full !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset: cnt=%0d ov=%b af=%b of=%b want 0",
               count, out_valid, almost_full, overflow);
    end
    do_reset();
  endtask

  task automatic test_single();
    in_valid = 1; in_data = 16'h1234;
    clk_step();
    in_valid = 0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 ||
          count !== 4'd1) begin
        n_err++;
        $display("FAIL single[%0d]: ov=%b d=%h c=%0d want 1 1234 1",
                 i, out_valid, out_data, count);
      end
      clk_step();
    end
    out_ready = 1;
    clk_step();
    out_ready = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_err++;
      $display("FAIL single_pop: ov=%b c=%0d want 0 0",
               out_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = 16'(i);
      clk_step();
      n_cmp++;
      if (count !== 4'(i) || almost_full !== (i >= AFULL)) begin
        n_err++;
        $display("FAIL fill[%0d]: c=%0d af=%b want %0d %b",
                 i, count, almost_full, i, (i >= AFULL));
      end
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        n_err++;
        $display("FAIL drain[%0d]: ov=%b d=%h want 1 %h",
                 i, out_valid, out_data, 16'(i));
      end
      clk_step();
    end
    out_ready = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_err++;
      $display("FAIL drained: ov=%b c=%0d want 0 0",
               out_valid, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_data = 16'h0100 + 16'(i);
      clk_step();
    end
    in_data = 16'hDEAD;
    clk_step();
    n_cmp++;
    if (overflow !== 1'b1 || count !== 4'd8 ||
        out_data !== 16'h0100) begin
      n_err++;
      $display("FAIL drop: of=%b c=%0d d=%h want 1 8 0100",
               overflow, count, out_data);
    end
    out_ready = 1;
    clk_step();
    out_ready = 0;
    n_cmp++;
    if (overflow !== 1'b1 || count !== 4'd8 ||
        out_data !== 16'h0101) begin
      n_err++;
      $display("FAIL push_pop_full: of=%b c=%0d d=%h want 1 8 0101",
               overflow, count, out_data);
    end
    // Clear coinciding with a drop leaves the flag set.
    ovf_clr = 1;
    clk_step();
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clr_vs_drop: of=%b want 1", overflow);
    end
    in_valid = 0;
    clk_step();
    ovf_clr = 0;
    n_cmp++;
    if (overflow !== 1'b0 || count !== 4'd8) begin
      n_err++;
      $display("FAIL clr: of=%b c=%0d want 0 8", overflow, count);
    end
    out_ready = 1;
    while (mq.size() != 0) begin
      n_cmp++;
      if (out_data !== mq[0]) begin
        n_err++;
        $display("FAIL ovf_drain: d=%h want %h", out_data, mq[0]);
      end
      clk_step();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_empty: ov=%b want 0", out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 16'h2000 + 16'(i);
      clk_step();
    end
    exp_out = 16'h2000;
    out_ready = 1;
    for (int i = 3; i < 23; i++) begin
      in_data = 16'h2000 + 16'(i);
      n_cmp++;
      if (out_data !== exp_out || count !== 4'd3) begin
        n_err++;
        $display("FAIL stream[%0d]: d=%h c=%0d want %h 3",
                 i, out_data, count, exp_out);
      end
      clk_step();
      exp_out++;
    end
    for (int i = 0; i < 10; i++) begin
      in_data = 16'h3000 + 16'(i);
      clk_step();
    end
    #2 rst_n = 0;
    #1;
    mq.delete();
    m_ovf = 0;
    n_cmp++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: c=%0d ov=%b want 0 0",
               count, out_valid);
    end
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1;
    in_valid = 1; in_data = 16'h4242;
    clk_step();
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h4242 ||
        count !== 4'd1) begin
      n_err++;
      $display("FAIL post_reset: ov=%b d=%h c=%0d want 1 4242 1",
               out_valid, out_data, count);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(99) < 65);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(99) < 50);
      ovf_clr   = ($urandom_range(99) < 8);
      clk_step();
      n_cmp++;
      if (count !== 4'(mq.size()) ||
          out_valid !== (mq.size() != 0) ||
          almost_full !== (mq.size() >= AFULL) ||
          overflow !== m_ovf ||
          (mq.size() != 0 && out_data !== mq[0])) begin
        n_err++;
        $display("FAIL rand[%0d]: c=%0d ov=%b af=%b of=%b d=%h want c=%0d of=%b",
                 i, count, out_valid, almost_full, overflow,
                 out_data, mq.size(), m_ovf);
      end
    end
    idle_inputs();
  endtask

`ifdef PIPE_OUT_PARITY_EN
  task automatic test_parity();
    logic [16:0] e;
    do_reset();
    in_valid = 1; in_data = 16'h00F0;
    clk_step();
    in_data = 16'h0F01;
    clk_step();
    in_valid = 0;
    e = dut.u_mem.mem_q[0];
    e[3] = ~e[3];
    dut.u_mem.mem_q[0] = e;
    #1;
    n_cmp++;
    if (out_par_err !== 1'b1) begin
      n_err++;
      $display("FAIL par_bad: pe=%b want 1", out_par_err);
    end
    out_ready = 1;
    clk_step();
    out_ready = 0;
    n_cmp++;
    if (out_par_err !== 1'b0 || out_data !== 16'h0F01) begin
      n_err++;
      $display("FAIL par_good: pe=%b d=%h want 0 0f01",
               out_par_err, out_data);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_random();
`ifdef PIPE_OUT_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
